// File: rtl/reg_desloc_pkg.sv
// reg_desloc_pkg: opcodes, FSM states and shared shift constants for the iterative shifter
package reg_desloc_pkg;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [4:0] SHAMT_DEZESSEIS = 5'd16;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/desloc_passo.sv
// desloc_passo: one 1-bit shift/rotate step of the operand
module desloc_passo
  import reg_desloc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_comb
    q = op == OP_SLL ? {d[WIDTH-2:0], 1'b0} :
        op == OP_SRL ? {1'b0, d[WIDTH-1:1]} :
        op == OP_SRA ? {d[WIDTH-1], d[WIDTH-1:1]} :
        op == OP_ROR ? {d[0], d[WIDTH-1:1]} :
        op == OP_ROL ? {d[WIDTH-2:0], d[WIDTH-1]} : d;
endmodule

// File: rtl/reg_desloc_iterativo.sv
// reg_desloc_iterativo: loads an operand then shifts/rotates it one bit per clock for n clocks
module reg_desloc_iterativo
  import reg_desloc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NBITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [NBITS-1:0] n,
  input  logic [WIDTH-1:0] entrada,
  output logic [WIDTH-1:0] saida,
  output logic             busy,
  output logic             done
);
  state_t           state_q;
  logic [2:0]       op_q;
  logic [NBITS-1:0] cnt_q;
  logic [WIDTH-1:0] saida_q, saida_d;
  logic             is_shift;
  desloc_passo #(.WIDTH(WIDTH)) u_passo (.op(op_q), .d(saida_q), .q(saida_d));
  assign is_shift = op >= OP_SLL && op <= OP_ROL;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      saida_q <= '0;
    end else
      case (state_q)
        IDLE:
          if (start) begin
            if (op == OP_LOAD) saida_q <= entrada;
            if (is_shift && n != '0) begin
              op_q    <= op;
              cnt_q   <= n;
              state_q <= RUN;
            end else
              state_q <= FIN;
          end
        RUN: begin
          saida_q <= saida_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == NBITS'(1)) state_q <= FIN;
        end
        default: state_q <= IDLE;
      endcase
  assign saida = saida_q;
  assign busy  = state_q == RUN;
  assign done  = state_q == FIN;
endmodule

// File: tb/tb_reg_desloc_iterativo.sv
// tb_reg_desloc_iterativo: randomized and directed checks against an arithmetic shift model
module tb_reg_desloc_iterativo;
  import reg_desloc_pkg::*;
  logic        clk = 0, reset = 1, start = 0;
  logic [2:0]  op = OP_NOP;
  logic [4:0]  n = '0;
  logic [31:0] entrada = '0, saida, m = '0;
  logic        busy, done;
  int vectors = 0, errors = 0;

  reg_desloc_iterativo dut (.clk(clk), .reset(reset), .start(start), .op(op), .n(n),
                            .entrada(entrada), .saida(saida), .busy(busy), .done(done));
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [4:0] k,
                                        input logic [31:0] d, input logic [31:0] cur);
    int s = int'(k);
    case (o)
      OP_LOAD: return d;
      OP_SLL:  return cur << s;
      OP_SRL:  return cur >> s;
      OP_SRA:  return 32'($signed(cur) >>> s);
      OP_ROR:  return s == 0 ? cur : (cur >> s) | (cur << (32 - s));
      OP_ROL:  return s == 0 ? cur : (cur << s) | (cur >> (32 - s));
      default: return cur;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [4:0] k, input logic [31:0] d, input bit poke);
    logic [31:0] exp;
    int lat;
    exp = model(o, k, d, m);
    lat = (o >= OP_SLL && o <= OP_ROL) ? int'(k) : 0;
    @(negedge clk); start = 1; op = o; n = k; entrada = d;
    @(negedge clk); start = poke; op = poke ? OP_LOAD : 3'($urandom); n = 5'($urandom); entrada = $urandom;
    for (int i = 0; i < lat; i++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_flags op=%0d n=%0d step %0d: busy=%b done=%b, want busy=1 done=0", o, k, i, busy, done);
      end
      @(negedge clk);
    end
    start = 0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse op=%0d n=%0d: busy=%b done=%b, want busy=0 done=1", o, k, busy, done);
    end
    vectors++;
    if (saida !== exp) begin
      errors++;
      $display("FAIL result op=%0d n=%0d: saida=%h, want %h", o, k, saida, exp);
    end
    m = exp;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_single op=%0d n=%0d: busy=%b done=%b, want 0 0", o, k, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 1; op = OP_LOAD; entrada = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    vectors++;
    if (saida !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: saida=%h busy=%b done=%b, want 00000000 0 0", saida, busy, done);
    end
    reset = 0; start = 0; m = '0;
    @(negedge clk);
  endtask

  task automatic test_load_sll();
    do_op(OP_LOAD, 5'd0, 32'h80000001, 0);
    do_op(OP_SLL, 5'd4, 32'h0, 0);
    vectors++;
    if (saida !== 32'h00000010) begin
      errors++;
      $display("FAIL load_sll: saida=%h, want 00000010", saida);
    end
  endtask

  task automatic test_sra16();
    do_op(OP_LOAD, 5'd0, 32'h80000000, 0);
    do_op(OP_SRA, SHAMT_DEZESSEIS, 32'h0, 0);
    vectors++;
    if (saida !== 32'hFFFF8000) begin
      errors++;
      $display("FAIL sra16: saida=%h, want FFFF8000", saida);
    end
  endtask

  task automatic test_srl_rot();
    do_op(OP_LOAD, 5'd0, 32'hFFFFFFFF, 0);
    do_op(OP_SRL, 5'd31, 32'h0, 0);
    vectors++;
    if (saida !== 32'h00000001) begin
      errors++;
      $display("FAIL srl31: saida=%h, want 00000001", saida);
    end
    do_op(OP_LOAD, 5'd0, 32'h12345678, 0);
    do_op(OP_ROR, 5'd8, 32'h0, 0);
    vectors++;
    if (saida !== 32'h78123456) begin
      errors++;
      $display("FAIL ror8: saida=%h, want 78123456", saida);
    end
    do_op(OP_LOAD, 5'd0, 32'h12345678, 0);
    do_op(OP_ROL, 5'd4, 32'h0, 0);
    vectors++;
    if (saida !== 32'h23456781) begin
      errors++;
      $display("FAIL rol4: saida=%h, want 23456781", saida);
    end
  endtask

  task automatic test_boundaries();
    do_op(OP_LOAD, 5'd0, 32'hA5A5_0F0F, 0);
    do_op(OP_SLL, 5'd0, 32'h0, 0);
    do_op(OP_NOP, 5'd9, 32'hFFFF_FFFF, 0);
    do_op(3'b111, 5'd3, 32'h1234_0000, 0);
    do_op(OP_SRL, 5'd7, 32'h0, 1);
    do_op(OP_ROL, 5'd31, 32'h0, 1);
  endtask

  task automatic test_reset_mid_run();
    do_op(OP_LOAD, 5'd0, 32'hCAFEF00D, 0);
    @(negedge clk); start = 1; op = OP_SLL; n = 5'd20;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk); reset = 0;
    vectors++;
    if (saida !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: saida=%h busy=%b done=%b, want 00000000 0 0", saida, busy, done);
    end
    m = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_run_idle: busy=%b done=%b, want 0 0", busy, done);
      end
    end
    do_op(OP_LOAD, 5'd0, 32'h0BAD_CAFE, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [2:0] o = 3'($urandom);
      if (i % 4 == 0) o = OP_LOAD;
      do_op(o, 5'($urandom), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_load_sll();
    test_sra16();
    test_srl_rot();
    test_boundaries();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
